// File: rtl/bd_router_pkg.sv
// Shared constants, stream indices and header-to-stream clamp for the BD output router.
package bd_router_pkg;

  localparam int BD_WORD_W  = 34;
  localparam int BD_HDR_W   = 4;
  localparam int BD_NUM_OUT = 4;

  typedef enum int unsigned {
    STREAM_SPIKE = 0,
    STREAM_TAG   = 1,
    STREAM_DUMP  = 2,
    STREAM_MISC  = 3
  } stream_e;

  // Headers beyond the last dedicated stream all fold into the final (misc) stream.
  function automatic int unsigned dest_of(input int unsigned hdr,
                                          input int unsigned num_out = BD_NUM_OUT);
    return (hdr < num_out - 1) ? hdr : num_out - 1;
  endfunction

endpackage

// File: rtl/bd_channel_if.sv
// Channel: data/valid/ack bundle used by the BD pin receiver and its consumers.
interface Channel #(parameter int W = 34);
  logic [W-1:0] d;
  logic         v;
  logic         a;

  modport sink   (input d, input v, output a);
  modport source (output d, output v, input a);
endinterface

// File: rtl/bd_word_fifo.sv
// Synchronous word FIFO; the head word is read straight out of the flop array.
module bd_word_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at power-of-2 depth; level alone separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bd_output_router.sv
// Buffers BD output words and steers each head word to its class stream by header.
// Optional per-stream pop counters are built when BD_ROUTER_COUNT_EN is defined.
module bd_output_router
  import bd_router_pkg::*;
#(
  parameter int WORD_W  = BD_WORD_W,
  parameter int HDR_W   = BD_HDR_W,
  parameter int NUM_OUT = BD_NUM_OUT,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  Channel.sink                     in_ch,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [WORD_W-HDR_W-1:0]  out_data,
  output logic [HDR_W-1:0]         out_code,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow_seen
`ifdef BD_ROUTER_COUNT_EN
  ,
  input  logic                     count_clr,
  output logic [NUM_OUT-1:0][15:0] word_count
`endif
);

  logic              ack_q;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [WORD_W-1:0] head;
  int unsigned       dest;

  // The ack flop doubles as the dead cycle: a held valid cannot be latched twice.
  assign accept  = in_ch.v & ~ack_q & ~fifo_full;
  assign in_ch.a = ack_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q         <= 1'b0;
      overflow_seen <= 1'b0;
    end else begin
      ack_q <= accept;
      if (in_ch.v & fifo_full) overflow_seen <= 1'b1;
    end
  end

  bd_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (in_ch.d),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_code = head[WORD_W-1 -: HDR_W];
  assign out_data = head[WORD_W-HDR_W-1:0];

  always_comb begin
    dest      = dest_of(32'(out_code), NUM_OUT);
    out_valid = '0;
    if (!fifo_empty) out_valid = NUM_OUT'(1) << dest;
  end

  // Only the destination stream's ready matters since out_valid is one-hot.
  assign pop = |(out_valid & out_ready);

`ifdef BD_ROUTER_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (count_clr)
          word_count[i] <= '0;
        else if (out_valid[i] && out_ready[i] && word_count[i] != 16'hFFFF)
          word_count[i] <= word_count[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bd_output_router.sv
// Scoreboard bench for bd_output_router: words queued at drive time, compared on pop.
module tb_bd_output_router;

  localparam int WORD_W  = 34;
  localparam int HDR_W   = 4;
  localparam int NUM_OUT = 4;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [29:0]        out_data;
  logic [3:0]         out_code;
  logic [4:0]         fifo_level;
  logic               overflow_seen;
`ifdef BD_ROUTER_COUNT_EN
  logic               count_clr;
  logic [NUM_OUT-1:0][15:0] word_count;
`endif

  Channel #(.W(WORD_W)) ch ();

  bd_output_router #(
    .WORD_W  (WORD_W),
    .HDR_W   (HDR_W),
    .NUM_OUT (NUM_OUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_ch         (ch),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_code      (out_code),
    .fifo_level    (fifo_level),
    .overflow_seen (overflow_seen)
`ifdef BD_ROUTER_COUNT_EN
    ,
    .count_clr     (count_clr),
    .word_count    (word_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acks   = 0;
  int          pops   = 0;
  bit          drv_en = 1'b0;
  logic [33:0] send_q[$];
  logic [33:0] sb_q[$];

  // Upstream model: present a word, hold it until ack is seen, then move on.
  task automatic driver();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ch.v && ch.a) begin
          acks++;
          ch.v = 1'b0;
        end
        if (!ch.v && drv_en && send_q.size() > 0) begin
          ch.d = send_q.pop_front();
          ch.v = 1'b1;
          sb_q.push_back(ch.d);
        end
      end
    end
  endtask

  task automatic monitor();
    logic [33:0] e;
    logic [3:0]  ev;
    int unsigned hd;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && (out_valid & out_ready) != 4'b0) begin
        checks++;
        pops++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected out_valid=%b out_data=%h expected no word", out_valid, out_data);
        end else begin
          e  = sb_q.pop_front();
          hd = 32'(e[33:30]);
          ev = 4'b0001 << ((hd < 3) ? hd : 3);
          if (out_valid !== ev || out_data !== e[29:0] || out_code !== e[33:30]) begin
            errors++;
            $display("FAIL pop_word got valid=%b code=%h data=%h expected valid=%b code=%h data=%h",
                     out_valid, out_code, out_data, ev, e[33:30], e[29:0]);
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((send_q.size() != 0 || sb_q.size() != 0 || ch.v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain timeout queued=%0d pending=%0d expected 0", name, send_q.size(), sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ch.v      = 1'b0;
    ch.d      = '0;
    out_ready = '0;
    #1;
    checks += 4;
    if (ch.a !== 1'b0)          begin errors++; $display("FAIL rst_ack got %b expected 0", ch.a); end
    if (out_valid !== 4'b0)     begin errors++; $display("FAIL rst_valid got %b expected 0000", out_valid); end
    if (fifo_level !== 5'd0)    begin errors++; $display("FAIL rst_level got %0d expected 0", fifo_level); end
    if (overflow_seen !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b expected 0", overflow_seen); end
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    drv_en = 1'b1;
  endtask

  task automatic test_single();
    int pulses = 0;
    out_ready = 4'b0000;
    send_q.push_back(34'h0_0000_0001);
    repeat (8) begin
      @(negedge clk);
      #2;
      if (ch.a) begin
        pulses++;
        checks++;
        if (out_valid !== 4'b0001) begin
          errors++;
          $display("FAIL single_valid_latency got %b expected 0001", out_valid);
        end
      end
    end
    checks += 3;
    if (pulses != 1)              begin errors++; $display("FAIL single_ack_pulses got %0d expected 1", pulses); end
    if (out_data !== 30'h1)       begin errors++; $display("FAIL single_data got %h expected 00000001", out_data); end
    if (fifo_level !== 5'd1)      begin errors++; $display("FAIL single_level got %0d expected 1", fifo_level); end
    out_ready = 4'b0001;
    wait_idle("single", 20);
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_pop_level got %0d expected 0", fifo_level); end
    out_ready = 4'b0000;
  endtask

  task automatic test_routing();
    int p0 = pops;
    out_ready = 4'b1111;
    send_q.push_back({4'd1, 30'h0000_1111});
    send_q.push_back({4'd2, 30'h0000_2222});
    send_q.push_back({4'd7, 30'h0000_3777});
    wait_idle("routing", 40);
    checks++;
    if (pops - p0 != 3) begin errors++; $display("FAIL routing_pops got %0d expected 3", pops - p0); end
    out_ready = 4'b0000;
  endtask

  task automatic test_overflow();
    int n  = 0;
    int a0 = acks;
    int p0 = pops;
    out_ready = 4'b0000;
    for (int i = 0; i < 17; i++) send_q.push_back({4'(i % 8), 30'(i + 100)});
    while (fifo_level != 5'd16 && n < 80) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    #2;
    checks += 5;
    if (fifo_level !== 5'd16)   begin errors++; $display("FAIL ovf_level got %0d expected 16", fifo_level); end
    if (ch.a !== 1'b0)          begin errors++; $display("FAIL ovf_ack got %b expected 0", ch.a); end
    if (ch.v !== 1'b1)          begin errors++; $display("FAIL ovf_held got v=%b expected 1", ch.v); end
    if (overflow_seen !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", overflow_seen); end
    if (sb_q.size() != 17)      begin errors++; $display("FAIL ovf_pending got %0d expected 17", sb_q.size()); end
    out_ready = 4'b1111;
    wait_idle("ovf", 200);
    checks += 3;
    if (acks - a0 != 17)        begin errors++; $display("FAIL ovf_acks got %0d expected 17", acks - a0); end
    if (pops - p0 != 17)        begin errors++; $display("FAIL ovf_pops got %0d expected 17", pops - p0); end
    if (overflow_seen !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", overflow_seen); end
    out_ready = 4'b0000;
  endtask

  task automatic test_hol();
    int n = 0;
    out_ready = 4'b1011;
    send_q.push_back({4'd2, 30'h0000_00AA});
    send_q.push_back({4'd0, 30'h0000_00BB});
    while (fifo_level != 5'd2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    checks += 3;
    if (out_valid !== 4'b0100) begin errors++; $display("FAIL hol_valid got %b expected 0100", out_valid); end
    if (fifo_level !== 5'd2)   begin errors++; $display("FAIL hol_level got %0d expected 2", fifo_level); end
    if (out_code !== 4'd2)     begin errors++; $display("FAIL hol_code got %0d expected 2", out_code); end
    @(negedge clk);
    out_ready = 4'b1111;
    wait_idle("hol", 20);
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL hol_drain_level got %0d expected 0", fifo_level); end
    out_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int a0;
    out_ready = 4'b0000;
    for (int i = 0; i < 6; i++) send_q.push_back({4'd1, 30'(i + 500)});
    while (!(fifo_level == 5'd5 && ch.a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    reset = 1'b1;
    #1;
    checks += 5;
    if (n >= 40)                begin errors++; $display("FAIL rmid_setup level=%0d expected 5 with ack", fifo_level); end
    if (ch.a !== 1'b0)          begin errors++; $display("FAIL rmid_ack got %b expected 0", ch.a); end
    if (out_valid !== 4'b0)     begin errors++; $display("FAIL rmid_valid got %b expected 0000", out_valid); end
    if (fifo_level !== 5'd0)    begin errors++; $display("FAIL rmid_level got %0d expected 0", fifo_level); end
    if (overflow_seen !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b expected 0", overflow_seen); end
    while (sb_q.size() > 1) sb_q.delete(0);
    repeat (3) @(negedge clk);
    a0    = acks;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    checks += 3;
    if (acks - a0 != 1)      begin errors++; $display("FAIL rmid_accept_once got %0d expected 1", acks - a0); end
    if (fifo_level !== 5'd1) begin errors++; $display("FAIL rmid_post_level got %0d expected 1", fifo_level); end
    if (ch.v !== 1'b0)       begin errors++; $display("FAIL rmid_v_dropped got %b expected 0", ch.v); end
    out_ready = 4'b1111;
    wait_idle("rmid", 20);
    out_ready = 4'b0000;
  endtask

`ifdef BD_ROUTER_COUNT_EN
  task automatic test_counters();
    int n = 0;
    @(negedge clk);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    #2;
    checks++;
    if (word_count[0] !== 16'd0) begin errors++; $display("FAIL cnt_clear got %0d expected 0", word_count[0]); end
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) send_q.push_back({4'd0, 30'(i)});
    send_q.push_back({4'd9, 30'h55});
    wait_idle("cnt", 40);
    checks += 3;
    if (word_count[0] !== 16'd3) begin errors++; $display("FAIL cnt_s0 got %0d expected 3", word_count[0]); end
    if (word_count[3] !== 16'd1) begin errors++; $display("FAIL cnt_s3 got %0d expected 1", word_count[3]); end
    if (word_count[1] !== 16'd0) begin errors++; $display("FAIL cnt_s1 got %0d expected 0", word_count[1]); end
    out_ready = 4'b0000;
    send_q.push_back({4'd0, 30'h77});
    while (fifo_level != 5'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    count_clr = 1'b1;
    out_ready = 4'b0001;
    @(negedge clk);
    count_clr = 1'b0;
    out_ready = 4'b0000;
    #2;
    checks += 2;
    if (word_count[0] !== 16'd0) begin errors++; $display("FAIL cnt_clr_priority got %0d expected 0", word_count[0]); end
    if (fifo_level !== 5'd0)     begin errors++; $display("FAIL cnt_clr_pop_level got %0d expected 0", fifo_level); end
  endtask
`endif

  initial begin
`ifdef BD_ROUTER_COUNT_EN
    count_clr = 1'b0;
`endif
    fork
      driver();
      monitor();
    join_none
    test_reset();
    test_single();
    test_routing();
    test_overflow();
    test_hol();
    test_reset_mid();
`ifdef BD_ROUTER_COUNT_EN
    test_counters();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
